// File: rtl/anc_sample_sched.sv
// anc_sample_sched: per-sample scheduler and startup sequencer for the ANC path.
// Discards SETTLE_N mic samples after reset, averages 2^CAL_LOG2 samples per
// channel into a DC offset, then streams offset-corrected stereo samples to the
// filter via flt_start/flt_done and latches results into the DAC registers.
// Overruns (sample arriving while busy) and filter timeouts are counted.
// Optional: define ANC_OFFSET_TRACK_EN to slowly track the DC offset in RUN.
module anc_sample_sched #(
  parameter int SETTLE_N = 1024,
  parameter int CAL_LOG2 = 8,
  parameter int TIMEOUT  = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [15:0] mic_l,
  input  logic [15:0] mic_r,
  input  logic        anc_en,
  output logic        flt_start,
  output logic [15:0] flt_x_l,
  output logic [15:0] flt_x_r,
  input  logic        flt_done,
  input  logic [15:0] flt_y,
  output logic [15:0] dac_l,
  output logic [15:0] dac_r,
  output logic        cal_ok,
  output logic [7:0]  overrun_cnt,
  output logic [1:0]  state_o
);

  localparam int SW = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
  localparam int CW = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW = 16 + CAL_LOG2;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_N - 1);
  localparam logic [CW-1:0] CAL_LAST    = CW'((1 << CAL_LOG2) - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_CAL    = 2'd1,
    S_IDLE   = 2'd2,
    S_BUSY   = 2'd3
  } state_t;

  state_t        state_q;
  logic [SW-1:0] settle_cnt_q;
  logic [CW-1:0] cal_cnt_q;
  logic [AW-1:0] acc_l_q, acc_r_q;
  logic [15:0]   off_l_q, off_r_q;
  logic [TW-1:0] to_cnt_q;
  logic          flt_start_q;
  logic [15:0]   flt_x_l_q, flt_x_r_q;
  logic [15:0]   dac_l_q, dac_r_q;
  logic          cal_ok_q;
  logic [7:0]    ovr_q;

  // combinational helpers
  logic [AW-1:0] acc_l_d, acc_r_d;
  logic [16:0]   diff_l, diff_r;
  logic [15:0]   corr_l, corr_r;
  logic          busy_abort;
  logic [7:0]    ovr_d;

  // Signed difference; a 16-bit minus 16-bit result always fits in 17 bits.
  function automatic logic [16:0] diff17(input logic [15:0] m, input logic [15:0] o);
    return {m[15], m} - {o[15], o};
  endfunction

  // Clamp a 17-bit signed value into the 16-bit signed range.
  function automatic logic [15:0] sat16(input logic [16:0] d);
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7fff;
    return d[15:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  // Accumulator next values, offset correction and overrun counter update.
  always_comb begin
    acc_l_d = acc_l_q + {{CAL_LOG2{mic_l[15]}}, mic_l};
    acc_r_d = acc_r_q + {{CAL_LOG2{mic_r[15]}}, mic_r};
    diff_l  = diff17(mic_l, off_l_q);
    diff_r  = diff17(mic_r, off_r_q);
    corr_l  = sat16(diff_l);
    corr_r  = sat16(diff_r);
    // flt_done takes priority over an expiring timeout.
    busy_abort = (state_q == S_BUSY) && !flt_done && (to_cnt_q == TO_LAST);
    ovr_d = ovr_q;
    if (busy_abort) ovr_d = sat_inc(ovr_d);
    if (state_q == S_BUSY && rx_done) ovr_d = sat_inc(ovr_d);
  end

`ifdef ANC_OFFSET_TRACK_EN
  logic signed [16:0] trk_step_l, trk_step_r;
  logic [16:0]        trk_sum_l, trk_sum_r;
  logic [15:0]        off_l_trk, off_r_trk;

  // Slow offset tracking: off += (mic - off) >>> 10, in 17 bits, truncated.
  always_comb begin
    trk_step_l = $signed(diff_l) >>> 10;
    trk_step_r = $signed(diff_r) >>> 10;
    trk_sum_l  = {off_l_q[15], off_l_q} + trk_step_l;
    trk_sum_r  = {off_r_q[15], off_r_q} + trk_step_r;
    off_l_trk  = trk_sum_l[15:0];
    off_r_trk  = trk_sum_r[15:0];
  end
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SETTLE;
      settle_cnt_q <= '0;
      cal_cnt_q    <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      off_l_q      <= '0;
      off_r_q      <= '0;
      to_cnt_q     <= '0;
      flt_start_q  <= 1'b0;
      flt_x_l_q    <= '0;
      flt_x_r_q    <= '0;
      dac_l_q      <= '0;
      dac_r_q      <= '0;
      cal_ok_q     <= 1'b0;
      ovr_q        <= '0;
    end else begin
      flt_start_q <= 1'b0;
      ovr_q       <= ovr_d;
      unique case (state_q)
        S_SETTLE: begin
          if (rx_done) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              settle_cnt_q <= '0;
              cal_cnt_q    <= '0;
              acc_l_q      <= '0;
              acc_r_q      <= '0;
              state_q      <= S_CAL;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
        end
        S_CAL: begin
          if (rx_done) begin
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            cal_cnt_q <= cal_cnt_q + 1'b1;
            // The completing sample is folded into the average, not processed.
            if (cal_cnt_q == CAL_LAST) begin
              off_l_q  <= acc_l_d[CAL_LOG2 +: 16];
              off_r_q  <= acc_r_d[CAL_LOG2 +: 16];
              cal_ok_q <= 1'b1;
              state_q  <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          // A stray flt_done here is ignored.
          if (rx_done) begin
            flt_x_l_q   <= corr_l;
            flt_x_r_q   <= corr_r;
            flt_start_q <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= S_BUSY;
`ifdef ANC_OFFSET_TRACK_EN
            off_l_q     <= off_l_trk;
            off_r_q     <= off_r_trk;
`endif
          end
        end
        S_BUSY: begin
          if (flt_done) begin
            dac_l_q <= flt_x_l_q;
            dac_r_q <= anc_en ? flt_y : 16'd0;
            state_q <= S_IDLE;
          end else if (busy_abort) begin
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_SETTLE;
      endcase
    end
  end

  assign flt_start   = flt_start_q;
  assign flt_x_l     = flt_x_l_q;
  assign flt_x_r     = flt_x_r_q;
  assign dac_l       = dac_l_q;
  assign dac_r       = dac_r_q;
  assign cal_ok      = cal_ok_q;
  assign overrun_cnt = ovr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_anc_sample_sched.sv
// Testbench for anc_sample_sched: directed test-plan steps followed by a random
// phase, all checked every cycle against a behavioural model of the sequencer.
module tb_anc_sample_sched;
  localparam int SN = 4;
  localparam int CL = 2;
  localparam int TO = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [15:0] mic_l = '0, mic_r = '0;
  logic        anc_en = 1'b0;
  logic        flt_done = 1'b0;
  logic [15:0] flt_y = '0;
  logic        flt_start;
  logic [15:0] flt_x_l, flt_x_r, dac_l, dac_r;
  logic        cal_ok;
  logic [7:0]  overrun_cnt;
  logic [1:0]  state_o;

  anc_sample_sched #(.SETTLE_N(SN), .CAL_LOG2(CL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .mic_l(mic_l), .mic_r(mic_r),
    .anc_en(anc_en), .flt_start(flt_start), .flt_x_l(flt_x_l), .flt_x_r(flt_x_r),
    .flt_done(flt_done), .flt_y(flt_y), .dac_l(dac_l), .dac_r(dac_r),
    .cal_ok(cal_ok), .overrun_cnt(overrun_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit en_g = 1'b1;

  // Behavioural model: mode 0 settle, 1 calibrate, 2 idle, 3 busy.
  int m_mode, m_settle, m_ncal, m_sum_l, m_sum_r, m_off_l, m_off_r;
  int m_xl, m_xr, m_start, m_dl, m_dr, m_calok, m_ovr, m_age;

  function automatic int fdiv(input int a, input int n);
    if (a >= 0) return a / n;
    return -((-a + n - 1) / n);
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] b;
    b = v[15:0];
    return int'(b);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_settle = 0; m_ncal = 0; m_sum_l = 0; m_sum_r = 0;
    m_off_l = 0; m_off_r = 0; m_xl = 0; m_xr = 0; m_start = 0;
    m_dl = 0; m_dr = 0; m_calok = 0; m_ovr = 0; m_age = 0;
  endtask

  task automatic bump();
    if (m_ovr < 255) m_ovr++;
  endtask

  task automatic m_step(input bit rx, input int ml, input int mr, input bit done,
                        input int y, input bit en);
    m_start = 0;
    case (m_mode)
      0: if (rx) begin
        m_settle++;
        if (m_settle == SN) begin
          m_mode = 1; m_ncal = 0; m_sum_l = 0; m_sum_r = 0;
        end
      end
      1: if (rx) begin
        m_sum_l += ml; m_sum_r += mr; m_ncal++;
        if (m_ncal == (1 << CL)) begin
          m_off_l = fdiv(m_sum_l, 1 << CL);
          m_off_r = fdiv(m_sum_r, 1 << CL);
          m_calok = 1; m_mode = 2;
        end
      end
      2: if (rx) begin
        m_xl = sat(ml - m_off_l);
        m_xr = sat(mr - m_off_r);
        m_start = 1; m_mode = 3; m_age = 0;
`ifdef ANC_OFFSET_TRACK_EN
        m_off_l = wrap16(m_off_l + fdiv(ml - m_off_l, 1024));
        m_off_r = wrap16(m_off_r + fdiv(mr - m_off_r, 1024));
`endif
      end
      default: begin
        if (done) begin
          m_dl = m_xl; m_dr = en ? y : 0; m_mode = 2;
        end else begin
          m_age++;
          if (m_age == TO) begin m_mode = 2; bump(); end
        end
        if (rx) bump();
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic signed [31:0] act, input int exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_all();
    chk("state", {30'd0, state_o}, m_mode);
    chk("flt_start", {31'd0, flt_start}, m_start);
    chk("flt_x_l", $signed(flt_x_l), m_xl);
    chk("flt_x_r", $signed(flt_x_r), m_xr);
    chk("dac_l", $signed(dac_l), m_dl);
    chk("dac_r", $signed(dac_r), m_dr);
    chk("cal_ok", {31'd0, cal_ok}, m_calok);
    chk("overrun_cnt", {24'd0, overrun_cnt}, m_ovr);
  endtask

  // One clock: drive inputs, step the model at the edge, check just after.
  task automatic cyc(input bit rx, input int ml, input int mr, input bit done, input int y);
    rx_done = rx; mic_l = 16'(ml); mic_r = 16'(mr);
    flt_done = done; flt_y = 16'(y); anc_en = en_g;
    @(posedge clk);
    if (rst) m_reset();
    else m_step(rx, ml, mr, done, y, en_g);
    #1;
    chk_all();
    rx_done = 1'b0; flt_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  int cal_l [4] = '{100, 102, 98, 100};
  int prev_dr;

  initial begin
    m_reset();
    #2;
    chk_all();                       // reset state
    @(posedge clk); #1;
    rst = 1'b0;

    // settle: samples ignored
    for (int i = 0; i < SN; i++) begin cyc(1, rnd16(), rnd16(), 0, 0); idle(1); end
    chk("in_cal", {30'd0, state_o}, 1);
    // calibration: off_l=100, off_r=-3
    for (int i = 0; i < 4; i++) begin cyc(1, cal_l[i], -3, 0, 0); idle(1); end
    chk("cal_done", {31'd0, cal_ok}, 1);

    // first sample: flt_start one clk after rx_done, correction and saturation
    cyc(1, 150, 32767, 0, 0);
    chk("start_lat", {31'd0, flt_start}, 1);
    chk("xl_150", $signed(flt_x_l), 50);
    chk("xr_sat_hi", $signed(flt_x_r), 32767);
    idle(2);
    cyc(0, 0, 0, 1, 'h1234);
    chk("dac_r_en", $signed(dac_r), 'h1234);

    // anc_en low: next completion writes dac_r=0
    en_g = 1'b0;
    cyc(1, 200, 0, 0, 0); idle(2);
    cyc(0, 0, 0, 1, 'h5555);
    chk("dac_r_dis", $signed(dac_r), 0);
    chk("dac_l_mon", $signed(dac_l), 100);
    en_g = 1'b1;

    // overrun: second sample while busy is dropped
    cyc(1, 120, 1, 0, 0);
    cyc(1, 999, 999, 0, 0);
    chk("ovr_one", {24'd0, overrun_cnt}, 1);
    chk("ovr_hold_x", $signed(flt_x_l), 20);
    chk("ovr_no_start", {31'd0, flt_start}, 0);
    cyc(0, 0, 0, 1, 77);

    // timeout: abort after TO cycles, outputs held, late flt_done ignored
    prev_dr = 77;
    cyc(1, 300, 300, 0, 0);
    idle(TO - 1);
    chk("to_still_busy", {30'd0, state_o}, 3);
    idle(1);
    chk("to_idle", {30'd0, state_o}, 2);
    chk("to_ovr", {24'd0, overrun_cnt}, 2);
    cyc(0, 0, 0, 1, 'h7777);
    chk("late_done", $signed(dac_r), prev_dr);

    // saturation of overrun_cnt
    cyc(1, 5, 5, 0, 0);
    repeat (300) cyc(1, rnd16(), rnd16(), 0, 0);
    chk("ovr_sat", {24'd0, overrun_cnt}, 255);
    cyc(0, 0, 0, 1, 11);

    // async reset mid-busy
    cyc(1, 400, 400, 0, 0);
    idle(1);
    rst = 1'b1;
    #1;
    m_reset();
    chk_all();
    chk("rst_calok", {31'd0, cal_ok}, 0);
    cyc(0, 0, 0, 1, 'h4321);
    chk("rst_done_ign", $signed(dac_r), 0);
    rst = 1'b0;
    idle(2);

    // recalibration with off_r=5, then negative saturation
    for (int i = 0; i < SN; i++) cyc(1, rnd16(), rnd16(), 0, 0);
    for (int i = 0; i < 4; i++) begin cyc(1, rnd16(), 5, 0, 0); idle(1); end
    cyc(1, 0, -32768, 0, 0);
    chk("xr_sat_lo", $signed(flt_x_r), -32768);
    cyc(0, 0, 0, 1, 3);

    // random traffic
    repeat (3000) begin
      en_g = ($urandom_range(7) != 0);
      cyc(($urandom_range(3) == 0), rnd16(), rnd16(), ($urandom_range(4) == 0), rnd16());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/anc_sample_sched.md
Name: anc_sample_sched

Overview:
- Per-sample scheduler and startup sequencer for the ANC datapath.
- Sits between the I2S mic receiver and the ANC filter, and between the filter and the codec DAC interface.
- After reset it discards mic settling samples, then measures the per-channel DC offset. From then on it feeds each offset-corrected stereo sample to the filter through a start/done handshake and latches the filter result into the DAC output registers.
- Detects filter overrun and filter timeout.

Parameters:
- SETTLE_N, 1024: mic samples discarded after reset before calibration.
- CAL_LOG2, 8: log2 of the samples averaged per channel for offset calibration.
- TIMEOUT, 2000: clk cycles allowed between flt_start and flt_done.

Ports:
- clk, in, 1: system clock; single clock domain.
- rst, in, 1: asynchronous, active-high reset.
- rx_done, in, 1: one-clk pulse; a new stereo mic sample is valid on mic_l/mic_r.
- mic_l, in, 16: signed left (reference) mic sample.
- mic_r, in, 16: signed right (error) mic sample.
- anc_en, in, 1: enables the anti-noise output; low forces dac_r to 0.
- flt_start, out, 1: one-clk pulse; flt_x_l/flt_x_r are valid.
- flt_x_l, out, 16: signed offset-corrected left sample to the filter.
- flt_x_r, out, 16: signed offset-corrected right sample to the filter.
- flt_done, in, 1: one-clk pulse; flt_y is valid.
- flt_y, in, 16: signed anti-noise result from the filter.
- dac_l, out, 16: signed monitor output (the corrected left sample).
- dac_r, out, 16: signed anti-noise output to the codec.
- cal_ok, out, 1: high once calibration has completed.
- overrun_cnt, out, 8: saturating count of dropped or aborted samples.
- state_o, out, 2: current state (0 SETTLE, 1 CAL, 2 RUN_IDLE, 3 RUN_BUSY).

Behaviour:
- Reset values (apply immediately on rst, at any time, including mid-calibration or mid-filter-operation):
  - state SETTLE; all counters, accumulators and offsets 0.
  - All outputs 0.
  - No flt_start is issued until re-calibration completes.
- SETTLE:
  - Count rx_done pulses.
  - On the SETTLE_N-th pulse, go to CAL with the accumulators cleared.
  - Samples seen in SETTLE are ignored.
- CAL:
  - On each rx_done: acc_l += mic_l and acc_r += mic_r, each sign-extended to 16+CAL_LOG2 bits. No overflow is possible.
  - After 2^CAL_LOG2 samples: off_l = acc_l >>> CAL_LOG2 and off_r = acc_r >>> CAL_LOG2 (arithmetic shift, truncated to 16 bits). Set cal_ok=1 and go to RUN_IDLE.
  - The rx_done that completes calibration is consumed by calibration, not processed.
- Correction (RUN states):
  - c = mic − off, computed in 17 bits, then saturated to [−32768, 32767].
- RUN_IDLE:
  - On rx_done, register c_l/c_r into flt_x_l/flt_x_r, pulse flt_start in the next cycle, and go to RUN_BUSY with the timeout counter at 0.
  - Latency rx_done → flt_start is 1 clk.
- RUN_BUSY:
  - flt_x is held stable.
  - On flt_done: dac_r = anc_en ? flt_y : 0, dac_l = flt_x_l (same cycle edge), then go to RUN_IDLE.
  - Latency flt_done → dac update is 1 clk.
- Overrun:
  - rx_done while in RUN_BUSY → the new sample is dropped and overrun_cnt is incremented (saturates at 255).
  - Busy processing continues unaffected.
- Timeout:
  - If TIMEOUT cycles elapse without flt_done → abort to RUN_IDLE. dac_r and dac_l hold their previous values and overrun_cnt is incremented.
  - A flt_done arriving while in RUN_IDLE is ignored.
- Simultaneous events in RUN_BUSY:
  - flt_done and rx_done in the same cycle: complete the current sample, drop the new one, and count an overrun.
  - flt_done and timeout in the same cycle: flt_done wins.
- anc_en:
  - Sampled only at the dac_r update.
  - If anc_en goes low, the next completed sample writes dac_r=0. dac_r is not cleared asynchronously.
- flt_start is only ever asserted in RUN; it is never asserted before cal_ok.

Optional Feature:
- Macro: ANC_OFFSET_TRACK_EN.
- Defined: in RUN, on each accepted rx_done, off += (mic − off) >>> 10 per channel. The update is applied after the correction for that sample is computed, and the arithmetic is done in 17 bits, truncated to 16.
- Undefined: offsets are frozen after CAL. No tracking logic is present.

Test Plan:
- Reset, then SETTLE_N=4 and CAL_LOG2=2 with mic_l=100, 102, 98, 100 after 4 discarded samples → cal_ok=1, off_l=100. A subsequent mic_l=150 gives flt_x_l=50 and flt_start one clk after rx_done.
- Negative offset: calibration on mic_r=−3 constant → off_r=−3. mic_r=32767 → flt_x_r saturates to 32767. After re-cal with off_r=5, mic_r=−32768 → flt_x_r=−32768.
- Handshake: flt_done with flt_y=0x1234 three clks after flt_start and anc_en=1 → dac_r=0x1234 one clk later. Repeat with anc_en=0 → dac_r=0.
- Overrun: second rx_done while BUSY → overrun_cnt 0→1, flt_x unchanged, no extra flt_start. 300 overruns → overrun_cnt=255.
- Timeout: flt_done withheld for 2000 cycles → state RUN_IDLE, dac_r unchanged, overrun_cnt+1. A late flt_done is then ignored.
- Reset asserted mid-RUN_BUSY → all outputs 0 asynchronously, state SETTLE, cal_ok=0. A flt_done arriving afterwards has no effect.
